// File: rtl/comma_align.sv
// 8b/10b comma aligner: finds K28.5 in the serial stream, frames 10-bit symbols on
// that boundary and re-aligns after MISALIGN_MAX consecutive off-boundary commas.
module comma_align #(
    parameter int unsigned MISALIGN_MAX = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ser_in,
    input  logic       ser_en,
    output logic [9:0] dout,
    output logic       dout_valid,
    output logic       locked,
    output logic       align_err
);

    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;
    localparam logic [3:0] ERR_LAST  = 4'(MISALIGN_MAX - 1);

    typedef enum logic {HUNT, SYNC} state_t;

    state_t     state, state_nx;
    logic [9:0] sr;
    logic [9:0] nw;
    logic       comma;
    logic [9:0] dout_nx;
    logic       dout_valid_nx, align_err_nx;
    logic [3:0] bit_cnt, bit_cnt_nx;
    logic [3:0] err_cnt, err_cnt_nx;

    // Candidate window includes the bit arriving on this edge, so a match is
    // acted on in the same edge that completes it.
    assign nw     = {sr[8:0], ser_in};
    assign comma  = (nw == K28_5_RDN) || (nw == K28_5_RDP);
    assign locked = (state == SYNC);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        state_nx      = state;
        dout_nx       = dout;
        dout_valid_nx = 1'b0;
        align_err_nx  = 1'b0;
        bit_cnt_nx    = bit_cnt;
        err_cnt_nx    = err_cnt;
        if (ser_en) begin
            unique case (state)
                HUNT: begin
                    if (comma) begin
                        state_nx      = SYNC;
                        dout_nx       = nw;
                        dout_valid_nx = 1'b1;
                        bit_cnt_nx    = 4'd0;
                        err_cnt_nx    = 4'd0;
                    end
                end
                SYNC: begin
                    if (bit_cnt == 4'd9) begin
                        dout_nx       = nw;
                        dout_valid_nx = 1'b1;
                        bit_cnt_nx    = 4'd0;
                        if (comma) err_cnt_nx = 4'd0;
                    end else begin
                        bit_cnt_nx = bit_cnt + 4'd1;
                        if (comma) begin
                            align_err_nx = 1'b1;
                            // The last tolerated miss moves the boundary to this comma.
                            if (err_cnt == ERR_LAST) begin
                                dout_nx       = nw;
                                dout_valid_nx = 1'b1;
                                bit_cnt_nx    = 4'd0;
                                err_cnt_nx    = 4'd0;
                            end else begin
                                err_cnt_nx = err_cnt + 4'd1;
                            end
                        end
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HUNT;
            sr         <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            align_err  <= 1'b0;
            bit_cnt    <= '0;
            err_cnt    <= '0;
        end else begin
            state      <= state_nx;
            dout       <= dout_nx;
            dout_valid <= dout_valid_nx;
            align_err  <= align_err_nx;
            bit_cnt    <= bit_cnt_nx;
            err_cnt    <= err_cnt_nx;
            if (ser_en) sr <= nw;
        end
    end

endmodule

// File: tb/tb_comma_align.sv
// Self-checking bench for comma_align: directed scenarios plus randomized traffic,
// compared against a bit-position model of word framing.
module tb_comma_align;

    localparam int         MAX = 3;
    localparam logic [9:0] RDN = 10'b0011111010;
    localparam logic [9:0] RDP = 10'b1100000101;
    localparam logic [9:0] ALT = 10'b0101010101;

    logic       clk = 1'b0;
    logic       reset, ser_in, ser_en;
    logic [9:0] dout;
    logic       dout_valid, locked, align_err;

    int checks = 0;
    int errors = 0;
    int valid_pulses, err_pulses;

    // Model: last ten accepted bits, total bits since reset, bit index of the
    // current framing boundary, and consecutive misaligned comma count.
    bit         mq[$];
    int         m_n, m_bound, m_miss;
    bit         m_locked, m_valid, m_err;
    logic [9:0] m_dout;

    comma_align #(.MISALIGN_MAX(MAX)) dut (
        .clk(clk), .reset(reset), .ser_in(ser_in), .ser_en(ser_en),
        .dout(dout), .dout_valid(dout_valid), .locked(locked), .align_err(align_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] window();
        logic [9:0] w = '0;
        foreach (mq[i]) w = {w[8:0], 1'(mq[i])};
        return w;
    endfunction

    task automatic model_edge(input bit b, input bit en, input bit rst);
        logic [9:0] w;
        bit         c;
        m_valid = 0;
        m_err   = 0;
        if (rst) begin
            mq.delete();
            m_n = 0; m_bound = 0; m_miss = 0; m_locked = 0; m_dout = '0;
            return;
        end
        if (!en) return;
        mq.push_back(b);
        if (mq.size() > 10) void'(mq.pop_front());
        m_n++;
        w = window();
        c = (w == RDN) || (w == RDP);
        if (!m_locked) begin
            if (c) begin
                m_locked = 1; m_bound = m_n; m_miss = 0; m_dout = w; m_valid = 1;
            end
        end else if ((m_n - m_bound) % 10 == 0) begin
            m_dout = w; m_valid = 1;
            if (c) m_miss = 0;
        end else if (c) begin
            m_err = 1;
            m_miss++;
            if (m_miss == MAX) begin
                m_bound = m_n; m_miss = 0; m_dout = w; m_valid = 1;
            end
        end
    endtask

    task automatic step(input bit b, input bit en, input bit rst, input string tag);
        reset  = rst;
        ser_in = b;
        ser_en = en;
        @(posedge clk);
        model_edge(b, en, rst);
        #1;
        check({tag, ".dout"}, dout, m_dout);
        check({tag, ".valid"}, 10'(dout_valid), 10'(m_valid));
        check({tag, ".locked"}, 10'(locked), 10'(m_locked));
        check({tag, ".align_err"}, 10'(align_err), 10'(m_err));
        valid_pulses += int'(dout_valid);
        err_pulses   += int'(align_err);
    endtask

    task automatic send_sym(input logic [9:0] sym, input bit gaps, input string tag);
        for (int i = 9; i >= 0; i--) begin
            if (gaps) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, tag);
            step(sym[i], 1'b1, 1'b0, tag);
        end
    endtask

    task automatic send_zeros(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, tag);
    endtask

    initial begin
        logic [9:0] first_dout;
        valid_pulses = 0;
        err_pulses   = 0;

        // Reset state
        step(1'b1, 1'b1, 1'b1, "reset");
        check("reset_dout_zero", dout, 10'h000);
        check("reset_locked_low", 10'(locked), 10'd0);

        // Lock on RD- comma
        send_sym(RDN, 1'b0, "lock");
        check("lock_dout", dout, 10'h0FA);
        check("lock_valid", 10'(dout_valid), 10'd1);
        check("lock_locked", 10'(locked), 10'd1);

        // Two aligned symbols 10 bits apart
        valid_pulses = 0;
        err_pulses   = 0;
        send_sym(RDP, 1'b0, "aligned1");
        first_dout = dout;
        check("aligned1_dout", first_dout, 10'h305);
        send_sym(ALT, 1'b0, "aligned2");
        check("aligned2_dout", dout, 10'h155);
        check("aligned_pulses", 10'(valid_pulses), 10'd2);
        check("aligned_no_err", 10'(err_pulses), 10'd0);

        // Three commas 3 bits off the boundary force re-alignment on the third
        err_pulses = 0;
        send_zeros(3, "mis_pad");
        for (int r = 0; r < 3; r++) begin
            send_sym(RDN, 1'b0, "mis_comma");
            if (r < 2) send_zeros(10, "mis_fill");
        end
        check("realign_err_pulses", 10'(err_pulses), 10'd3);
        check("realign_valid", 10'(dout_valid), 10'd1);
        check("realign_dout", dout, RDN);
        check("realign_locked", 10'(locked), 10'd1);
        send_sym(ALT, 1'b0, "realign_next");
        check("realign_next_valid", 10'(dout_valid), 10'd1);
        check("realign_next_dout", dout, ALT);

        // Comma stream with ser_en gaps
        step(1'b0, 1'b0, 1'b1, "gap_reset");
        valid_pulses = 0;
        send_sym(RDN, 1'b1, "gap_c1");
        check("gap_c1_dout", dout, RDN);
        send_sym(RDP, 1'b1, "gap_c2");
        check("gap_c2_dout", dout, RDP);
        send_sym(RDN, 1'b1, "gap_c3");
        check("gap_c3_dout", dout, RDN);
        check("gap_pulses", 10'(valid_pulses), 10'd3);

        // Reset five bits into a locked symbol, then non-comma data
        for (int i = 9; i >= 5; i--) step(ALT[i], 1'b1, 1'b0, "midsym");
        step(1'b0, 1'b1, 1'b1, "midsym_reset");
        check("midsym_locked", 10'(locked), 10'd0);
        check("midsym_dout", dout, 10'h000);
        send_sym(ALT, 1'b0, "nolock1");
        send_sym(ALT, 1'b0, "nolock2");
        check("nolock_locked", 10'(locked), 10'd0);
        send_sym(RDP, 1'b0, "relock");
        check("relock_locked", 10'(locked), 10'd1);

        // Reset on the same edge that completes a comma
        step(1'b0, 1'b1, 1'b1, "race_pre");
        for (int i = 9; i >= 1; i--) step(RDN[i], 1'b1, 1'b0, "race_bits");
        step(RDN[0], 1'b1, 1'b1, "race_edge");
        check("race_locked", 10'(locked), 10'd0);
        check("race_valid", 10'(dout_valid), 10'd0);

        // Randomized traffic with occasional commas at random phases
        for (int it = 0; it < 400; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if ($urandom_range(0, 149) == 0) begin
                step(1'b0, 1'b1, 1'b1, "rnd_reset");
            end else if (r < 3) begin
                send_sym(($urandom_range(0, 1) != 0) ? RDN : RDP,
                         ($urandom_range(0, 3) == 0), "rnd_comma");
            end else begin
                int n;
                n = int'($urandom_range(1, 12));
                for (int k = 0; k < n; k++)
                    step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'b0, "rnd_bits");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
